// File: rtl/dispatch_pkg.sv
// Shared class encodings, opcode constants and the opcode decoder for the dispatch unit.
package dispatch_pkg;

  typedef enum logic [1:0] {
    CLS_INT = 2'd0,
    CLS_FP  = 2'd1,
    CLS_MEM = 2'd2,
    CLS_SYS = 2'd3
  } dispatch_cls_e;

  localparam int unsigned NUM_CLS = 4;

  // INT
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  // FP
  localparam logic [6:0] OP_MADD      = 7'b1000011;
  localparam logic [6:0] OP_MSUB      = 7'b1000111;
  localparam logic [6:0] OP_NMSUB     = 7'b1001011;
  localparam logic [6:0] OP_NMADD     = 7'b1001111;
  localparam logic [6:0] OP_OP_FP     = 7'b1010011;
  // MEM
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_LOAD_FP   = 7'b0000111;
  localparam logic [6:0] OP_STORE_FP  = 7'b0100111;
  // SYS
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;

  typedef struct packed {
    logic          legal;
    dispatch_cls_e cls;
  } decode_t;

  // Every listed opcode has [1:0]=2'b11, so compressed encodings fall into the default.
  function automatic decode_t decode_op(input logic [6:0] op);
    decode_t d;
    d.legal = 1'b1;
    d.cls   = CLS_INT;
    case (op)
      OP_OP, OP_OP_IMM, OP_OP_32, OP_OP_IMM_32, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:           d.cls = CLS_INT;
      OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD,
      OP_OP_FP:                                    d.cls = CLS_FP;
      OP_LOAD, OP_STORE, OP_LOAD_FP, OP_STORE_FP:  d.cls = CLS_MEM;
      OP_SYSTEM, OP_MISC_MEM:                      d.cls = CLS_SYS;
      default:                                     d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dispatch_ifq.sv
// First-word-fall-through fetch queue with registered full/empty, overflow pulse and flush.
module dispatch_ifq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            enq,
  input  logic [XLEN-1:0] wdata,
  input  logic            deq,
  output logic [XLEN-1:0] head,
  output logic            full,
  output logic            empty,
  output logic            ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [AW:0]     wr_ptr_nxt, rd_ptr_nxt;
  logic            do_wr, do_rd;

  // Accept writes only when not full; a same-cycle pop never frees a slot early.
  always_comb begin
    do_wr      = enq & ~full & ~flush;
    do_rd      = deq & ~empty & ~flush;
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_wr};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_rd};
  end

  // Pointers and status flags; flags derive from next pointers so they stay registered.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      ovf    <= enq & full;
    end
  end

  // Storage array; contents need no reset since empty gates their use.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dispatch_unit.sv
// In-order dispatcher: decodes the fetch-queue head and issues it to one of four issue queues.
module dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IFQ_DEPTH = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     ifq_enq,
  input  logic [XLEN-1:0]          ifq_data,
  output logic                     ifq_full,
  output logic                     ifq_empty,
  output logic                     ifq_ovf,
  input  logic                     dispatch_en,
  input  logic [NUM_CLS-1:0]       iq_full,
  input  logic [NUM_CLS-1:0]       iq_afull,
  output logic [NUM_CLS-1:0]       iq_enq,
  output logic [XLEN-1:0]          iq_data,
  output logic                     illegal,
  output logic [XLEN-1:0]          illegal_instr,
  output logic [NUM_CLS*CNT_W-1:0] stall_cnt
);

  logic [XLEN-1:0]    head;
  decode_t            dec;
  logic [1:0]         cls_idx;
  logic [NUM_CLS-1:0] onehot;
  logic               blocked;
  logic               head_ok;
  logic               fire;
  logic               stall_hit;
  logic [CNT_W-1:0]   cnt_q [NUM_CLS];

  dispatch_ifq #(
    .XLEN  (XLEN),
    .DEPTH (IFQ_DEPTH)
  ) u_ifq (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .enq   (ifq_enq),
    .wdata (ifq_data),
    .deq   (fire),
    .head  (head),
    .full  (ifq_full),
    .empty (ifq_empty),
    .ovf   (ifq_ovf)
  );

  // Decode head and decide fire; afull with an enqueue in flight counts as full.
  always_comb begin
    dec       = decode_op(head[6:0]);
    cls_idx   = dec.cls;
    onehot    = '0;
    onehot[cls_idx] = 1'b1;
    blocked   = iq_full[cls_idx] | (iq_afull[cls_idx] & iq_enq[cls_idx]);
    head_ok   = ~ifq_empty & dispatch_en & ~flush;
    fire      = head_ok & (~dec.legal | ~blocked);
    stall_hit = head_ok & dec.legal & blocked;
  end

  // Registered dispatch and illegal-drop outputs; data buses hold between events.
  always_ff @(posedge clk) begin
    if (reset) begin
      iq_enq        <= '0;
      iq_data       <= '0;
      illegal       <= 1'b0;
      illegal_instr <= '0;
    end else begin
      iq_enq  <= (fire & dec.legal) ? onehot : '0;
      illegal <= fire & ~dec.legal;
      if (fire & dec.legal)  iq_data       <= head;
      if (fire & ~dec.legal) illegal_instr <= head;
    end
  end

  // Per-class saturating stall counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CLS; c++) cnt_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CLS; c++) begin
        if (stall_hit && (cls_idx == 2'(c)) && (cnt_q[c] != '1))
          cnt_q[c] <= cnt_q[c] + 1'b1;
      end
    end
  end

  // Pack counters onto the flat output bus.
  always_comb begin
    stall_cnt = '0;
    for (int unsigned c = 0; c < NUM_CLS; c++) stall_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: expected dispatches queued at write time, popped on output.
module tb_dispatch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              ifq_enq = 1'b0;
  logic [XLEN-1:0]   ifq_data = '0;
  logic              ifq_full, ifq_empty, ifq_ovf;
  logic              dispatch_en = 1'b0;
  logic [3:0]        iq_full = '0;
  logic [3:0]        iq_afull = '0;
  logic [3:0]        iq_enq;
  logic [XLEN-1:0]   iq_data;
  logic              illegal;
  logic [XLEN-1:0]   illegal_instr;
  logic [4*CNT_W-1:0] stall_cnt;

  dispatch_unit #(.XLEN(XLEN), .IFQ_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ifq_enq(ifq_enq), .ifq_data(ifq_data),
    .ifq_full(ifq_full), .ifq_empty(ifq_empty), .ifq_ovf(ifq_ovf),
    .dispatch_en(dispatch_en), .iq_full(iq_full), .iq_afull(iq_afull),
    .iq_enq(iq_enq), .iq_data(iq_data),
    .illegal(illegal), .illegal_instr(illegal_instr),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ill;
    logic [3:0]  enq;
    logic [31:0] data;
  } item_t;

  item_t sb[$];
  int    ev_cycles[$];
  int    cyc_no  = 0;
  int    ovf_cnt = 0;
  int    n_chk   = 0;
  int    n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic item_t ref_item(input logic [31:0] d);
    item_t it;
    it.ill  = 1'b0;
    it.enq  = 4'b0000;
    it.data = d;
    case (d[6:0])
      7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: it.enq = 4'b0001;
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111, 7'b1010011: it.enq = 4'b0010;
      7'b0000011, 7'b0100011, 7'b0000111, 7'b0100111: it.enq = 4'b0100;
      7'b1110011, 7'b0001111: it.enq = 4'b1000;
      default: it.ill = 1'b1;
    endcase
    return it;
  endfunction

  always @(posedge clk) cyc_no++;

  // Monitor: every dispatch or illegal pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    item_t e;
    if (ifq_ovf) ovf_cnt++;
    if (iq_enq != 4'b0000 || illegal) begin
      ev_cycles.push_back(cyc_no);
      if (sb.size() == 0) begin
        check("unexpected_dispatch", {27'd0, illegal, iq_enq, iq_data}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("dispatch", {27'd0, illegal, iq_enq, illegal ? illegal_instr : iq_data},
              {27'd0, e.ill, e.enq, e.data});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input bit accepted);
    ifq_enq  = 1'b1;
    ifq_data = d;
    if (accepted) sb.push_back(ref_item(d));
    cyc();
    ifq_enq = 1'b0;
  endtask

  task automatic check_consecutive(input string tag, input int n);
    check({tag, "_count"}, 64'(ev_cycles.size()), 64'(n));
    for (int i = 1; i < ev_cycles.size(); i++)
      check({tag, "_gap"}, 64'(ev_cycles[i] - ev_cycles[i-1]), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"},
          {59'd0, iq_enq, illegal},
          64'd0);
    check({tag, "_flags"}, {61'd0, ifq_ovf, ifq_full, ifq_empty}, 64'd1);
    check({tag, "_data"}, {iq_data, illegal_instr}, 64'd0);
    check({tag, "_stall"}, stall_cnt, 64'd0);
  endtask

  logic [15:0] s0;
  logic [63:0] st_snap;
  int          rel;
  logic [6:0]  ops [20];

  initial begin
    ops = '{7'b0110011, 7'b0111011, 7'b0011011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1000011, 7'b1000111,
            7'b1001011, 7'b1001111, 7'b0100011, 7'b0000111, 7'b0100111,
            7'b0001111, 7'b1111111, 7'b0000010, 7'b1011011, 7'b1110011};

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    check_reset_outputs("reset");
    cyc();
    reset = 1'b0;
    dispatch_en = 1'b1;
    cyc();

    // Single INT: enqueue exactly two cycles after the write
    wr(32'h00500093, 1'b1);
    @(negedge clk);
    check("t1_lat1_enq", 64'(iq_enq), 64'd0);
    check("t1_lat1_empty", 64'(ifq_empty), 64'd0);
    @(negedge clk);
    check("t1_lat2_enq", 64'(iq_enq), 64'b0001);
    check("t1_data", 64'(iq_data), 64'h00500093);
    check("t1_empty", 64'(ifq_empty), 64'd1);
    repeat (3) cyc();

    // Burst alternating FP / MEM with no gaps
    ev_cycles.delete();
    for (int i = 0; i < 8; i++) wr((i % 2 == 0) ? 32'h0020F053 : 32'h0000A103, 1'b1);
    repeat (4) cyc();
    check_consecutive("t2", 8);
    check("t2_drain", 64'(sb.size()), 64'd0);

    // MEM backpressure: afull then full
    dispatch_en = 1'b0;
    for (int i = 0; i < 3; i++) wr(32'h0000A103 + (32'(i) << 20), 1'b1);
    s0 = stall_cnt[2*CNT_W +: CNT_W];
    ev_cycles.delete();
    iq_afull[2] = 1'b1;
    dispatch_en = 1'b1;
    cyc();
    iq_full[2] = 1'b1;
    repeat (5) cyc();
    check("t3_one_enq", 64'(ev_cycles.size()), 64'd1);
    check("t3_stall", 64'(stall_cnt[2*CNT_W +: CNT_W] - s0), 64'd5);
    iq_full[2]  = 1'b0;
    iq_afull[2] = 1'b0;
    rel = cyc_no;
    repeat (4) cyc();
    check("t3_resume_count", 64'(ev_cycles.size()), 64'd3);
    if (ev_cycles.size() > 1)
      check("t3_resume_cycle", 64'(ev_cycles[1]), 64'(rel + 1));
    check("t3_stall_after", 64'(stall_cnt[2*CNT_W +: CNT_W] - s0), 64'd5);
    check("t3_other_stall", {stall_cnt[3*CNT_W +: CNT_W], stall_cnt[CNT_W +: CNT_W], stall_cnt[0 +: CNT_W]}, 64'd0);

    // Fill to full, overflow, drain
    dispatch_en = 1'b0;
    ovf_cnt = 0;
    for (int i = 0; i < 8; i++) wr(32'h00100093 + (32'(i) << 20), 1'b1);
    check("t4_full", 64'(ifq_full), 64'd1);
    wr(32'h00900093, 1'b0);
    @(negedge clk);
    check("t4_ovf", 64'(ifq_ovf), 64'd1);
    cyc();
    check("t4_ovf_once", 64'(ovf_cnt), 64'd1);
    ev_cycles.delete();
    dispatch_en = 1'b1;
    repeat (12) cyc();
    check_consecutive("t4", 8);
    check("t4_empty", 64'(ifq_empty), 64'd1);

    // Illegal head followed by SYS
    ev_cycles.delete();
    wr(32'h00000000, 1'b1);
    wr(32'h00000073, 1'b1);
    repeat (4) cyc();
    check_consecutive("t5", 2);
    check("t5_instr", 64'(illegal_instr), 64'd0);

    // Decode sweep across every class and several illegal opcodes
    for (int i = 0; i < 20; i++) wr({18'(i * 3 + 1), 7'd0, ops[i]}, 1'b1);
    repeat (6) cyc();
    check("sweep_drain", 64'(sb.size()), 64'd0);

    // Flush with five queued and one enqueue in flight
    dispatch_en = 1'b0;
    for (int i = 0; i < 6; i++) wr(32'h00200093 + (32'(i) << 20), 1'b1);
    dispatch_en = 1'b1;
    cyc();
    st_snap = stall_cnt;
    flush = 1'b1;
    ifq_enq = 1'b1;
    ifq_data = 32'h00A00093;
    cyc();
    flush = 1'b0;
    ifq_enq = 1'b0;
    sb.delete();
    ev_cycles.delete();
    @(negedge clk);
    check("t6_empty", 64'(ifq_empty), 64'd1);
    check("t6_enq", 64'(iq_enq), 64'd0);
    check("t6_ovf", 64'(ifq_ovf), 64'd0);
    repeat (4) cyc();
    check("t6_no_more", 64'(ev_cycles.size()), 64'd0);
    check("t6_stall", stall_cnt, st_snap);

    // Reset mid-burst
    wr(32'h00300093, 1'b1);
    wr(32'h0020F053, 1'b1);
    wr(32'h0000A103, 1'b1);
    reset = 1'b1;
    cyc();
    sb.delete();
    @(negedge clk);
    check_reset_outputs("t7");
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    check("t7_idle", 64'(iq_enq), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
